// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pkg
//  Purpose  : Shared types and sizing helpers for the serial sample loader.
//  Revision : 1.0  initial parametrised release
// ============================================================================
package serial_pkg;

    // Handshake FSM: wait for a write, then hold the ack until the HPS drops it.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    // Number of LANES-wide words needed to cover NUM_SAMPLES samples.
    function automatic int num_words(input int num_samples, input int lanes);
        return (num_samples + lanes - 1) / lanes;
    endfunction

    // Counter width able to hold the value num_words itself.
    function automatic int cnt_w(input int nwords);
        return $clog2(nwords + 1);
    endfunction

    // Width of an in-range word index (at least one bit).
    function automatic int widx_w(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_sample_bank.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sample_bank
//  Purpose  : Flat sample store with a LANES-wide write port addressed by word
//             index, synchronous clear and a flat read-out bus.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module serial_sample_bank #(
    parameter int NUM_SAMPLES = 256,
    parameter int LANES       = 4,
    parameter int SAMPLE_W    = 8,
    parameter int WIDX_W      = 6
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic                            we_i,
    input  logic [WIDX_W-1:0]               widx_i,
    input  logic [LANES*SAMPLE_W-1:0]       wdata_i,
    output logic [NUM_SAMPLES*SAMPLE_W-1:0] data_o
);

    // One register per element; each element knows statically which word and
    // lane feed it, so lanes past the last element simply have no destination.
    for (genvar e = 0; e < NUM_SAMPLES; e++) begin : g_elem
        localparam int WORD = e / LANES;
        localparam int LANE = e % LANES;

        logic [SAMPLE_W-1:0] elem_q;

        // Element storage: clear wins over a write in the same cycle.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                elem_q <= '0;
            end else if (clear_i) begin
                elem_q <= '0;
            end else if (we_i && (widx_i == WIDX_W'(WORD))) begin
                elem_q <= wdata_i[LANE*SAMPLE_W +: SAMPLE_W];
            end
        end

        assign data_o[e*SAMPLE_W +: SAMPLE_W] = elem_q;
    end

endmodule : serial_sample_bank
`default_nettype wire

// File: rtl/serial_sample_loader.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sample_loader
//  Purpose  : Accepts LANES samples per HPS handshake at a word index, stores
//             input/expected/valid arrays, tracks loaded words, reports
//             completion and flags out-of-range indices.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module serial_sample_loader
    import serial_pkg::*;
#(
    parameter  int NUM_SAMPLES = 256,
    parameter  int LANES       = 4,
    parameter  int SAMPLE_W    = 8,
    parameter  int IDX_W       = 32,
    localparam int NUM_WORDS   = num_words(NUM_SAMPLES, LANES),
    localparam int CNT_W       = cnt_w(NUM_WORDS)
) (
    input  logic                            iClock,
    input  logic                            iReset_n,
    input  logic [LANES*SAMPLE_W-1:0]       iSampleIn,
    input  logic [LANES*SAMPLE_W-1:0]       iExpectedIn,
    input  logic [LANES*SAMPLE_W-1:0]       iValidIn,
    input  logic [IDX_W-1:0]                iSampleIndex,
    input  logic                            iWriteSample,
    input  logic                            iPreparingNextSample,
    input  logic                            iClear,
    output logic [NUM_SAMPLES*SAMPLE_W-1:0] oInputSequences,
    output logic [NUM_SAMPLES*SAMPLE_W-1:0] oExpectedOutputs,
    output logic [NUM_SAMPLES*SAMPLE_W-1:0] oValidOutputs,
    output logic                            oNextSample,
    output logic [CNT_W-1:0]                oLoadedCount,
    output logic                            oLoadDone,
    output logic                            oIndexError
);

    localparam int WIDX_W = widx_w(NUM_WORDS);

    state_e               state_q, state_d;
    logic                 ack_q, ack_d;
    logic [NUM_WORDS-1:0] bitmap_q, bitmap_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 w_in_range;
    logic                 w_bank_we;
    logic                 w_already;
    logic [NUM_WORDS-1:0] w_word_hit;
    logic [WIDX_W-1:0]    w_widx;

    // Range check on the full index width, before any truncation.
    assign w_in_range = (iSampleIndex < IDX_W'(NUM_WORDS));
    // Truncated index only reaches the banks when the write is in range.
    assign w_widx     = iSampleIndex[WIDX_W-1:0];

    // One-hot decode of the full index against every legal word.
    always_comb begin
        w_word_hit = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            w_word_hit[w] = (iSampleIndex == IDX_W'(w));
        end
    end

    assign w_already = |(bitmap_q & w_word_hit);

    // Next-state and bookkeeping; clear overrides any handshake activity.
    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        bitmap_d  = bitmap_q;
        count_d   = count_q;
        err_d     = err_q;
        w_bank_we = 1'b0;

        if (iClear) begin
            state_d  = IDLE;
            ack_d    = 1'b0;
            bitmap_d = '0;
            count_d  = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iWriteSample && !iPreparingNextSample) begin
                        ack_d   = 1'b1;
                        state_d = ACK;
                        if (w_in_range) begin
                            w_bank_we = 1'b1;
                            bitmap_d  = bitmap_q | w_word_hit;
                            if (!w_already) begin
                                count_d = count_q + CNT_W'(1);
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (!iWriteSample) begin
                        ack_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            endcase
        end

        done_d = (count_d == CNT_W'(NUM_WORDS));
    end

    // Control and status registers.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            bitmap_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            bitmap_q <= bitmap_d;
            count_q  <= count_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    serial_sample_bank #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .LANES       (LANES),
        .SAMPLE_W    (SAMPLE_W),
        .WIDX_W      (WIDX_W)
    ) u_bank_input (
        .clk_i   (iClock),
        .rst_ni  (iReset_n),
        .clear_i (iClear),
        .we_i    (w_bank_we),
        .widx_i  (w_widx),
        .wdata_i (iSampleIn),
        .data_o  (oInputSequences)
    );

    serial_sample_bank #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .LANES       (LANES),
        .SAMPLE_W    (SAMPLE_W),
        .WIDX_W      (WIDX_W)
    ) u_bank_expected (
        .clk_i   (iClock),
        .rst_ni  (iReset_n),
        .clear_i (iClear),
        .we_i    (w_bank_we),
        .widx_i  (w_widx),
        .wdata_i (iExpectedIn),
        .data_o  (oExpectedOutputs)
    );

    serial_sample_bank #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .LANES       (LANES),
        .SAMPLE_W    (SAMPLE_W),
        .WIDX_W      (WIDX_W)
    ) u_bank_valid (
        .clk_i   (iClock),
        .rst_ni  (iReset_n),
        .clear_i (iClear),
        .we_i    (w_bank_we),
        .widx_i  (w_widx),
        .wdata_i (iValidIn),
        .data_o  (oValidOutputs)
    );

    assign oNextSample  = ack_q;
    assign oLoadedCount = count_q;
    assign oLoadDone    = done_q;
    assign oIndexError  = err_q;

endmodule : serial_sample_loader
`default_nettype wire
